memwb_skid_reg: RTL

- Parametrised MEM/WB pipeline register for the pipelined CPU, placed between the data-memory stage and register-file write-back.
- Generalises the fixed-width MEM/WB latch:
  - configurable data and register-index widths;
  - valid/ready handshake on both sides, backed by a 2-entry skid buffer;
  - synchronous flush;
  - write-enable qualification;
  - retired-instruction counter.
- Back-pressure from write-back therefore never drops a MEM-stage result.

---
 rtl/memwb_skid_reg.sv | 122 ++++++++++++
 1 files changed

// File: rtl/memwb_skid_reg.sv
// MEM/WB pipeline register with valid/ready handshake on both sides, a 2-entry
// skid buffer, synchronous flush, qualified write enable and a retire counter.
module memwb_skid_reg #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [1:0]        WB_i,
  input  logic [DATA_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [REG_W-1:0]  rd_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              MemtoReg_o,
  output logic              RegWrite_o,
  output logic [DATA_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o,
  output logic [REG_W-1:0]  rd_o,
  output logic [CNT_W-1:0]  retire_cnt_o
);

  typedef struct packed {
    logic [1:0]        wb;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [REG_W-1:0]  rd;
  } entry_t;

  // Encoded as {M.valid, S.valid}; 2'b01 cannot occur.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } state_e;

  state_e           state_q, state_d;
  entry_t           in_entry, m_q, s_q;
  logic             in_ready_q;
  logic [CNT_W-1:0] retire_q;
  logic             accept, pop;
  logic             load_m, load_s, move_s;

  assign in_entry = '{wb: WB_i, addr: addr_i, data: data_i, rd: rd_i};
  assign accept   = in_valid_i & in_ready_q;
  assign pop      = state_q[1] & out_ready_i;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    load_m  = 1'b0;
    load_s  = 1'b0;
    move_s  = 1'b0;
    case (state_q)
      EMPTY: if (accept) begin
        load_m  = 1'b1;
        state_d = ONE;
      end
      ONE: begin
        if (accept && pop) begin
          load_m = 1'b1;
        end else if (accept) begin
          load_s  = 1'b1;
          state_d = FULL;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: if (pop) begin
        move_s  = 1'b1;
        state_d = ONE;
      end
      default: state_d = EMPTY;
    endcase
    // Flush beats everything; a coincident pop is still counted below.
    if (flush_i) begin
      state_d = EMPTY;
      load_m  = 1'b0;
      load_s  = 1'b0;
      move_s  = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      retire_q   <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != FULL);
      if (pop) retire_q <= retire_q + CNT_W'(1);
    end
  end

  // NOTE: payload is reset too, because the outputs it drives must read 0 in reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      m_q <= '0;
      s_q <= '0;
    end else begin
      if (load_m)      m_q <= in_entry;
      else if (move_s) m_q <= s_q;
      if (load_s)      s_q <= in_entry;
    end
  end

  assign in_ready_o   = in_ready_q;
  assign out_valid_o  = state_q[1];
  assign MemtoReg_o   = m_q.wb[0] & state_q[1];
  assign RegWrite_o   = m_q.wb[1] & state_q[1] & (m_q.rd != '0);
  assign addr_o       = m_q.addr;
  assign data_o       = m_q.data;
  assign rd_o         = m_q.rd;
  assign retire_cnt_o = retire_q;

endmodule
